// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multicycle fp_adder between two requesters.
// Define FP_ARB_SUB_EN to let reqN_sub flip the sign of b (a-b).
module fp_add_arbiter #(
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_sub,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_sub,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_sum,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_sum,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic             gnt0;
   logic             gnt1;
   logic             accept;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b_raw;
   logic [31:0]      sel_b;
   logic             sel_sub;

   always_comb begin
      gnt0 = req0_valid && (!req1_valid || last_grant);
      gnt1 = req1_valid && (!req0_valid || !last_grant);
   end

   // Ready is also held low while reset is asserted.
   assign req0_ready = reset && (state == IDLE) && gnt0;
   assign req1_ready = reset && (state == IDLE) && gnt1;
   assign accept     = (req0_valid && req0_ready) ||
                       (req1_valid && req1_ready);

   always_comb begin
      sel_a     = gnt1 ? req1_a : req0_a;
      sel_b_raw = gnt1 ? req1_b : req0_b;
      sel_sub   = gnt1 ? req1_sub : req0_sub;
   end

`ifdef FP_ARB_SUB_EN
   assign sel_b = sel_sub ? {~sel_b_raw[31], sel_b_raw[30:0]}
                          : sel_b_raw;
`else
   logic unused_sub;
   assign unused_sub = sel_sub;
   assign sel_b      = sel_b_raw;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         rsp_sum    <= '0;
         rsp_id     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  op_a       <= sel_a;
                  op_b       <= sel_b;
                  rsp_id     <= gnt1;
                  last_grant <= gnt1;
                  cnt        <= CNT_W'(LATENCY - 1);
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  rsp_sum <= add_sum;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operands stay registered in every state to keep the adder quiet.
   assign add_a     = op_a;
   assign add_b     = op_b;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter (LATENCY=2 and LATENCY=1 instances).
// The adder is modelled by a lookup of the operand pairs used here.
module tb_fp_add_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] sum;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        req0_valid = 0, req1_valid = 0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic        req0_sub = 0, req1_sub = 0;
   logic        rsp_valid, rsp_id, busy;
   logic        rsp_ready = 1;
   logic [31:0] rsp_sum, add_a, add_b, add_sum;

   logic        l_req0_valid = 0, l_req1_valid = 0;
   logic        l_req0_ready, l_req1_ready;
   logic [31:0] l_req0_a = 0, l_req0_b = 0, l_req1_a = 0, l_req1_b = 0;
   logic        l_rsp_valid, l_rsp_id, l_busy;
   logic        l_rsp_ready = 1;
   logic [31:0] l_rsp_sum, l_add_a, l_add_b, l_add_sum;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t e;

   function automatic logic [31:0] fadd(input logic [31:0] a,
                                        input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40000000, 32'h3F800000}: return 32'h40400000;
         {32'h40400000, 32'h3F800000}: return 32'h40800000;
         {32'h40400000, 32'hBF800000}: return 32'h40000000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         default: return a ^ {b[15:0], b[31:16]};
      endcase
   endfunction

   assign add_sum   = fadd(add_a, add_b);
   assign l_add_sum = fadd(l_add_a, l_add_b);

   fp_add_arbiter #(.LATENCY(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .busy(busy)
   );

   fp_add_arbiter #(.LATENCY(1), .CNT_W(4)) dut_l1 (
      .clk(clk), .reset(reset),
      .req0_valid(l_req0_valid), .req0_ready(l_req0_ready),
      .req0_a(l_req0_a), .req0_b(l_req0_b), .req0_sub(1'b0),
      .req1_valid(l_req1_valid), .req1_ready(l_req1_ready),
      .req1_a(l_req1_a), .req1_b(l_req1_b), .req1_sub(1'b0),
      .rsp_valid(l_rsp_valid), .rsp_ready(l_rsp_ready),
      .rsp_id(l_rsp_id), .rsp_sum(l_rsp_sum),
      .add_a(l_add_a), .add_b(l_add_b), .add_sum(l_add_sum),
      .busy(l_busy)
   );

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      sb.delete();
   endtask

   task automatic wait_rsp_pop(input string name);
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: rsp_valid=%b want 1", name, rsp_valid);
      end
      n_chk++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s_sb_empty: got response with no expected entry", name);
      end else begin
         e = sb.pop_front();
         if ({rsp_id, rsp_sum} !== {e.id, e.sum}) begin
            n_fail++;
            $display("FAIL %s_rsp: got id=%b sum=%h want id=%b sum=%h",
                     name, rsp_id, rsp_sum, e.id, e.sum);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      n_chk++;
      if ({busy, rsp_valid, req0_ready, req1_ready, rsp_id} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {busy, rsp_valid, req0_ready, req1_ready, rsp_id});
      end
      n_chk++;
      if ({add_a, add_b, rsp_sum} !== 96'b0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h want 0", add_a, add_b, rsp_sum);
      end
      n_chk++;
      if ({l_busy, l_rsp_valid, l_req0_ready} !== 3'b0) begin
         n_fail++;
         $display("FAIL reset_l1: got %b want 000",
                  {l_busy, l_rsp_valid, l_req0_ready});
      end
      req0_valid = 0; req1_valid = 0;
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      #1;
      n_chk++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      e.id = 0; e.sum = 32'h40400000; sb.push_back(e);
      req0_valid = 0; req0_a = 32'hDEADBEEF;
      n_chk++;
      if ({busy, rsp_valid, add_a, add_b} !==
          {2'b10, 32'h3F800000, 32'h40000000}) begin
         n_fail++;
         $display("FAIL single_exec: got %b%b %h %h want 10 3f800000 40000000",
                  busy, rsp_valid, add_a, add_b);
      end
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: rsp_valid=%b want 0 in cycle 2", rsp_valid);
      end
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_cycle3: rsp_valid=%b want 1", rsp_valid);
      end
      wait_rsp_pop("single");
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: busy=%b want 0 in cycle 4", busy);
      end
   endtask

   task automatic test_alternate();
      int ng, nr;
      int g[4];
      int acc_c[4];
      ng = 0; nr = 0;
      do_reset();
      req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            if (ng < 4) begin g[ng] = int'(req1_ready); acc_c[ng] = c; end
            ng++;
            e.id = req1_ready;
            e.sum = req1_ready ? 32'h40800000 : 32'h40400000;
            sb.push_back(e);
         end
         if (rsp_valid) begin
            wait_rsp_pop("alt");
            nr++;
         end
         if (nr == 4) break;
         @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
      n_chk++;
      if (nr != 4 || ng != 4) begin
         n_fail++;
         $display("FAIL alt_count: got %0d rsp %0d grants want 4 4", nr, ng);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (g[i] != (i % 2)) begin
               n_fail++;
               $display("FAIL alt_grant%0d: got %0d want %0d", i, g[i], i % 2);
            end
         end
         for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (acc_c[i+1] - acc_c[i] != 4) begin
               n_fail++;
               $display("FAIL alt_interval%0d: got %0d want 4",
                        i, acc_c[i+1] - acc_c[i]);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      rsp_ready = 0;
      req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40000000;
      #1;
      n_chk++;
      if (req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_accept: req0_ready=%b want 1", req0_ready);
      end
      @(negedge clk);
      e.id = 0; e.sum = 32'h40800000; sb.push_back(e);
      req0_valid = 0;
      req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if ({rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready} !==
             {1'b1, 32'h40800000, 3'b000}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b sum=%h id=%b rdy=%b%b want 1 40800000 0 00",
                     i, rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready);
         end
      end
      rsp_ready = 1;
      wait_rsp_pop("bp");
      @(negedge clk);
      n_chk++;
      if ({busy, rsp_valid, req1_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL bp_release: got %b want 001", {busy, rsp_valid, req1_ready});
      end
      req1_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_sub();
      logic [31:0] want_b;
`ifdef FP_ARB_SUB_EN
      want_b = 32'hBF800000; e.sum = 32'h40000000;
`else
      want_b = 32'h3F800000; e.sum = 32'h40800000;
`endif
      e.id = 0;
      req0_valid = 1; req0_sub = 1;
      req0_a = 32'h40400000; req0_b = 32'h3F800000;
      @(negedge clk);
      sb.push_back(e);
      req0_valid = 0; req0_sub = 0;
      n_chk++;
      if (add_b !== want_b) begin
         n_fail++;
         $display("FAIL sub_add_b: got %h want %h", add_b, want_b);
      end
      wait_rsp_pop("sub");
      @(negedge clk);
   endtask

   task automatic test_reset_exec();
      req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40000000;
      @(negedge clk);
      req0_valid = 0;
      reset = 1'b0;
      #1;
      n_chk++;
      if ({busy, rsp_valid, req0_ready, req1_ready, rsp_id} !== 5'b0) begin
         n_fail++;
         $display("FAIL rexec_ctrl: got %b want 00000",
                  {busy, rsp_valid, req0_ready, req1_ready, rsp_id});
      end
      n_chk++;
      if ({add_a, add_b, rsp_sum} !== 96'b0) begin
         n_fail++;
         $display("FAIL rexec_data: got %h %h %h want 0", add_a, add_b, rsp_sum);
      end
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
      #1;
      n_chk++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL rexec_tie: got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      e.id = 0; e.sum = 32'h40400000; sb.push_back(e);
      req0_valid = 0; req1_valid = 0;
      wait_rsp_pop("rexec");
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL rexec_drain: busy=%b pending=%0d want 0 0", busy, sb.size());
      end
   endtask

   task automatic test_latency1();
      l_req0_valid = 1; l_req0_a = 32'h3F800000; l_req0_b = 32'h40000000;
      #1;
      n_chk++;
      if (l_req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL l1_ready: got %b want 1", l_req0_ready);
      end
      @(negedge clk);
      e.id = 0; e.sum = 32'h40400000; sb.push_back(e);
      l_req0_valid = 0; l_req0_a = 32'h12345678;
      #1;
      n_chk++;
      if ({l_busy, l_rsp_valid, l_add_a} !== {2'b10, 32'h3F800000}) begin
         n_fail++;
         $display("FAIL l1_exec: got %b%b %h want 10 3f800000",
                  l_busy, l_rsp_valid, l_add_a);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if ({l_rsp_valid, l_rsp_id, l_rsp_sum, l_add_a} !==
          {1'b1, e.id, e.sum, 32'h3F800000}) begin
         n_fail++;
         $display("FAIL l1_rsp: got v=%b id=%b sum=%h add_a=%h want 1 %b %h 3f800000",
                  l_rsp_valid, l_rsp_id, l_rsp_sum, l_add_a, e.id, e.sum);
      end
      @(negedge clk);
      n_chk++;
      if (l_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL l1_idle: busy=%b want 0", l_busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_sub();
      test_reset_exec();
      test_latency1();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
